lab1_imul_mul_arbiter: RTL and testbench

- Shares one iterative integer multiplier (val/rdy request and response ports) between two independent requesters.
- Accepts one request at a time using round-robin arbitration and forwards it to the multiplier.
- Routes the multiplier's response back to the requester that issued it.
- Sits between the test sources/sinks (or two client pipelines) and a single lab1 multiplier instance. Keeps at most one transaction in flight.

---
 rtl/lab1_imul_mul_arbiter.sv | 116 +++++++++++
 tb/tb_lab1_imul_mul_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_mul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier between two val/rdy requesters.
// One transaction in flight; the response is routed back to the requester that issued it.
module lab1_imul_mul_arbiter #(
  parameter int unsigned p_req_nbits  = 64,
  parameter int unsigned p_resp_nbits = 32,
  parameter int unsigned p_cnt_nbits  = 16
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    in0_req_val,
  output logic                    in0_req_rdy,
  input  logic [p_req_nbits-1:0]  in0_req_msg,

  input  logic                    in1_req_val,
  output logic                    in1_req_rdy,
  input  logic [p_req_nbits-1:0]  in1_req_msg,

  output logic                    out0_resp_val,
  input  logic                    out0_resp_rdy,
  output logic                    out1_resp_val,
  input  logic                    out1_resp_rdy,
  output logic [p_resp_nbits-1:0] out_resp_msg,

  output logic                    mul_req_val,
  input  logic                    mul_req_rdy,
  output logic [p_req_nbits-1:0]  mul_req_msg,

  input  logic                    mul_resp_val,
  output logic                    mul_resp_rdy,
  input  logic [p_resp_nbits-1:0] mul_resp_msg,

  output logic                    busy,
  output logic [p_cnt_nbits-1:0]  cnt0,
  output logic [p_cnt_nbits-1:0]  cnt1
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_prio;
  logic                    r_owner;
  logic [p_req_nbits-1:0]  r_msg;
  logic [p_cnt_nbits-1:0]  r_cnt0;
  logic [p_cnt_nbits-1:0]  r_cnt1;

  logic w_idle;
  logic w_issue;
  logic w_wait;
  logic w_grant_any;
  logic w_grant_sel;
  logic w_owner_rdy;

  // State decodes are qualified by reset so every val/rdy output is low while reset is held.
  always_comb begin
    w_idle      = !reset && (r_state == ST_IDLE);
    w_issue     = !reset && (r_state == ST_ISSUE);
    w_wait      = !reset && (r_state == ST_WAIT);
    w_grant_any = in0_req_val | in1_req_val;
    w_grant_sel = (in0_req_val & in1_req_val) ? r_prio : in1_req_val;
    w_owner_rdy = r_owner ? out1_resp_rdy : out0_resp_rdy;
  end

  assign in0_req_rdy   = w_idle & in0_req_val & ~w_grant_sel;
  assign in1_req_rdy   = w_idle & in1_req_val &  w_grant_sel;

  assign mul_req_val   = w_issue;
  assign mul_req_msg   = r_msg;

  assign out0_resp_val = w_wait & ~r_owner & mul_resp_val;
  assign out1_resp_val = w_wait &  r_owner & mul_resp_val;
  assign mul_resp_rdy  = w_wait & w_owner_rdy;
  assign out_resp_msg  = w_wait ? mul_resp_msg : '0;

  assign busy = (r_state != ST_IDLE);
  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_msg   <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_msg   <= w_grant_sel ? in1_req_msg : in0_req_msg;
            r_owner <= w_grant_sel;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mul_req_rdy) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_resp_val && w_owner_rdy) begin
            if (!r_owner && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + p_cnt_nbits'(1);
            if ( r_owner && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + p_cnt_nbits'(1);
            r_prio  <= ~r_owner;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
// Self-checking bench for lab1_imul_mul_arbiter: a bench-side multiplier drives the shared port,
// and a round-robin/completion-count model predicts grants, routing and counters.
module tb_lab1_imul_mul_arbiter;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          in0_req_val, in0_req_rdy;
  logic [63:0]   in0_req_msg;
  logic          in1_req_val, in1_req_rdy;
  logic [63:0]   in1_req_msg;
  logic          out0_resp_val, out0_resp_rdy;
  logic          out1_resp_val, out1_resp_rdy;
  logic [31:0]   out_resp_msg;
  logic          mul_req_val, mul_req_rdy;
  logic [63:0]   mul_req_msg;
  logic          mul_resp_val, mul_resp_rdy;
  logic [31:0]   mul_resp_msg;
  logic          busy;
  logic [CW-1:0] cnt0, cnt1;

  int n_vec;
  int n_err;

  // Reference model: priority holder and raw completion totals per requester.
  int m_prio;
  int m_done0;
  int m_done1;

  lab1_imul_mul_arbiter #(
    .p_req_nbits (64),
    .p_resp_nbits(32),
    .p_cnt_nbits (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in0_req_val  (in0_req_val),
    .in0_req_rdy  (in0_req_rdy),
    .in0_req_msg  (in0_req_msg),
    .in1_req_val  (in1_req_val),
    .in1_req_rdy  (in1_req_rdy),
    .in1_req_msg  (in1_req_msg),
    .out0_resp_val(out0_resp_val),
    .out0_resp_rdy(out0_resp_rdy),
    .out1_resp_val(out1_resp_val),
    .out1_resp_rdy(out1_resp_rdy),
    .out_resp_msg (out_resp_msg),
    .mul_req_val  (mul_req_val),
    .mul_req_rdy  (mul_req_rdy),
    .mul_req_msg  (mul_req_msg),
    .mul_resp_val (mul_resp_val),
    .mul_resp_rdy (mul_resp_rdy),
    .mul_resp_msg (mul_resp_msg),
    .busy         (busy),
    .cnt0         (cnt0),
    .cnt1         (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  function automatic int exp_grant(input bit v0, input bit v1);
    if (v0 && v1) return m_prio;
    return v1 ? 1 : 0;
  endfunction

  function automatic int exp_cnt(input int done);
    return (done > CMAX) ? CMAX : done;
  endfunction

  task automatic model_commit(input int eg);
    if (eg == 0) m_done0++;
    else         m_done1++;
    m_prio = 1 - eg;
  endtask

  task automatic clear_inputs();
    in0_req_val = 0; in1_req_val = 0; in0_req_msg = '0; in1_req_msg = '0;
    out0_resp_rdy = 0; out1_resp_rdy = 0;
    mul_req_rdy = 0; mul_resp_val = 0; mul_resp_msg = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_prio = 0; m_done0 = 0; m_done1 = 0;
  endtask

  // Plays requesters and multiplier for one transaction; records observations, compares nothing.
  // perr reports the first protocol step seen misbehaving (0 = none).
  task automatic run_txn(input bit v0, input bit v1, input logic [63:0] m0, input logic [63:0] m1,
                         input int istall, input int rstall, output int g, output logic [63:0] iss,
                         output int rport, output logic [31:0] rmsg, output int perr);
    logic [31:0]   prod;
    logic [CW-1:0] c0, c1;
    int n;
    g = -1; iss = '0; rport = -1; rmsg = '0; perr = 0; n = 0;
    in0_req_msg = m0; in1_req_msg = m1; in0_req_val = v0; in1_req_val = v1;
    #1;
    while (!in0_req_rdy && !in1_req_rdy && n < 8) begin @(posedge clk); #2; n++; end
    if (!in0_req_rdy && !in1_req_rdy) begin
      perr = 1; in0_req_val = 0; in1_req_val = 0;
      return;
    end
    if (in0_req_rdy && in1_req_rdy) perr = 2;
    g = in1_req_rdy ? 1 : 0;
    @(posedge clk); #1;
    in0_req_val = 1; in1_req_val = 1; mul_req_rdy = 0;
    mul_resp_val = 1; mul_resp_msg = $urandom;
    #1;
    if (!mul_req_val || !busy) perr = 3;
    iss = mul_req_msg;
    for (int i = 0; i < istall; i++) begin
      if (!mul_req_val || mul_req_msg !== iss || in0_req_rdy || in1_req_rdy || mul_resp_rdy ||
          out0_resp_val || out1_resp_val || out_resp_msg !== '0) perr = 4;
      @(posedge clk); #2;
    end
    if (in0_req_rdy || in1_req_rdy || mul_resp_rdy || out0_resp_val || out1_resp_val) perr = 4;
    mul_req_rdy = 1;
    @(posedge clk); #1;
    mul_req_rdy = 0; in0_req_val = 0; in1_req_val = 0;
    prod = iss[63:32] * iss[31:0];
    mul_resp_msg = prod;
    out0_resp_rdy = (g == 1); out1_resp_rdy = (g == 0);
    #1;
    if (mul_req_val || !busy || in0_req_rdy || in1_req_rdy) perr = 5;
    c0 = cnt0; c1 = cnt1;
    for (int i = 0; i < rstall; i++) begin
      if (mul_resp_rdy || out_resp_msg !== prod || (out0_resp_val == out1_resp_val) ||
          cnt0 !== c0 || cnt1 !== c1 || !busy) perr = 6;
      @(posedge clk); #2;
    end
    out0_resp_rdy = (g == 0); out1_resp_rdy = (g == 1);
    #1;
    rport = (out0_resp_val && !out1_resp_val) ? 0 : (out1_resp_val && !out0_resp_val) ? 1 : 2;
    rmsg = out_resp_msg;
    if (!mul_resp_rdy) perr = 7;
    @(posedge clk); #1;
    mul_resp_val = 0; out0_resp_rdy = 0; out1_resp_rdy = 0;
    #1;
    if (busy || mul_req_val) perr = 8;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1; in0_req_val = 1; in1_req_val = 1; mul_req_rdy = 1;
    mul_resp_val = 1; out0_resp_rdy = 1; out1_resp_rdy = 1;
    @(posedge clk); #2;
    n_vec++;
    if ({in0_req_rdy, in1_req_rdy, mul_req_val, mul_resp_rdy, out0_resp_val, out1_resp_val} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_valrdy got %b exp 000000",
               {in0_req_rdy, in1_req_rdy, mul_req_val, mul_resp_rdy, out0_resp_val, out1_resp_val});
    end
    n_vec++;
    if (busy !== 1'b0 || out_resp_msg !== 32'h0) begin
      n_err++; $display("FAIL reset_busy_msg got %b/%h exp 0/0", busy, out_resp_msg);
    end
    n_vec++;
    if (cnt0 !== '0 || cnt1 !== '0) begin
      n_err++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", cnt0, cnt1);
    end
    @(posedge clk); #1;
    reset = 0; clear_inputs();
    #1;
    n_vec++;
    if (in0_req_rdy || in1_req_rdy || busy) begin
      n_err++; $display("FAIL idle_noreq got rdy%b%b busy%b exp 000", in0_req_rdy, in1_req_rdy, busy);
    end
    m_prio = 0; m_done0 = 0; m_done1 = 0;
  endtask

  // mode: 0 both valid, 1 port1 only, 3 port0 only (fixed 3x4), 2 random mix; stall <0 means random.
  task automatic test_traffic(input string tag, input int n, input int mode, input int istall, input int rstall);
    bit v0, v1;
    int r, is, rs, g, eg, rport, perr;
    logic [63:0] m0, m1, iss, em;
    logic [31:0] rmsg, eprod;
    for (int i = 0; i < n; i++) begin
      m0 = {$urandom, $urandom}; m1 = {$urandom, $urandom};
      case (mode)
        0: begin v0 = 1; v1 = 1; end
        1: begin v0 = 0; v1 = 1; end
        3: begin v0 = 1; v1 = 0; m0 = 64'h00000003_00000004; end
        default: begin r = $urandom_range(1, 3); v0 = r[0]; v1 = r[1]; end
      endcase
      is = (istall < 0) ? $urandom_range(0, 3) : istall;
      rs = (rstall < 0) ? $urandom_range(0, 3) : rstall;
      eg = exp_grant(v0, v1);
      em = (eg == 1) ? m1 : m0;
      eprod = em[63:32] * em[31:0];
      run_txn(v0, v1, m0, m1, is, rs, g, iss, rport, rmsg, perr);
      model_commit(eg);
      n_vec++;
      if (perr !== 0) begin n_err++; $display("FAIL %s[%0d] protocol_step got %0d exp 0", tag, i, perr); end
      n_vec++;
      if (g !== eg) begin n_err++; $display("FAIL %s[%0d] grant got %0d exp %0d", tag, i, g, eg); end
      n_vec++;
      if (iss !== em) begin n_err++; $display("FAIL %s[%0d] mul_req_msg got %h exp %h", tag, i, iss, em); end
      n_vec++;
      if (rport !== eg) begin n_err++; $display("FAIL %s[%0d] resp_port got %0d exp %0d", tag, i, rport, eg); end
      n_vec++;
      if (rmsg !== eprod) begin n_err++; $display("FAIL %s[%0d] resp_msg got %h exp %h", tag, i, rmsg, eprod); end
      n_vec++;
      if (cnt0 !== CW'(exp_cnt(m_done0)) || cnt1 !== CW'(exp_cnt(m_done1))) begin
        n_err++;
        $display("FAIL %s[%0d] counters got %0d/%0d exp %0d/%0d", tag, i, cnt0, cnt1,
                 exp_cnt(m_done0), exp_cnt(m_done1));
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    n = 0;
    @(posedge clk); #1;
    in0_req_msg = {$urandom, $urandom}; in0_req_val = 1;
    #1;
    while (!in0_req_rdy && n < 8) begin @(posedge clk); #2; n++; end
    n_vec++;
    if (!in0_req_rdy) begin n_err++; $display("FAIL rst_wait_grant got 0 exp 1"); end
    @(posedge clk); #1;
    in0_req_val = 0; mul_req_rdy = 1;
    @(posedge clk); #1;
    mul_req_rdy = 0; mul_resp_val = 1; mul_resp_msg = $urandom; out0_resp_rdy = 0;
    #1;
    n_vec++;
    if (!busy || mul_req_val) begin n_err++; $display("FAIL rst_wait_state got busy%b val%b exp busy1 val0", busy, mul_req_val); end
    reset = 1;
    @(posedge clk); #1;
    reset = 0; out0_resp_rdy = 1; out1_resp_rdy = 1;
    #1;
    n_vec++;
    if (busy || out0_resp_val || out1_resp_val || mul_resp_rdy || mul_req_val) begin
      n_err++;
      $display("FAIL rst_wait_outputs got busy%b v%b%b rdy%b mv%b exp all 0",
               busy, out0_resp_val, out1_resp_val, mul_resp_rdy, mul_req_val);
    end
    n_vec++;
    if (cnt0 !== '0 || cnt1 !== '0) begin n_err++; $display("FAIL rst_wait_cnt got %0d/%0d exp 0/0", cnt0, cnt1); end
    clear_inputs();
    m_prio = 0; m_done0 = 0; m_done1 = 0;
    test_traffic("post_rst_p1", 1, 1, 0, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1;
    clear_inputs();
    m_prio = 0; m_done0 = 0; m_done1 = 0;
    test_reset();
    test_traffic("single_p0", 1, 3, 0, 0);
    do_reset();
    test_traffic("both_first", 1, 0, 0, 0);
    test_traffic("held_p1", 1, 1, 0, 0);
    test_traffic("prio_back0", 1, 0, 0, 0);
    do_reset();
    test_traffic("alternate", 6, 0, -1, -1);
    test_traffic("issue_stall", 2, 0, 5, 0);
    test_traffic("resp_stall", 2, 0, 0, 4);
    test_reset_in_wait();
    test_traffic("random", 20, 2, -1, -1);
    do_reset();
    test_traffic("saturate", 34, 0, -1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
